// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4
//   Scans a 4x4 matrix keypad one row at a time, synchronises the column
//   sense lines, classifies each full scan and debounces presses and
//   releases.  Each accepted key yields its hex code and is shifted into a
//   four-digit buffer for the seven-segment scanner.
//
//   Optional build macro: KEYPAD_REPEAT_EN
//     When defined, a key held alone in the pressed state re-emits its
//     code every REPEAT_SCANS full scans (auto-repeat).
//     When undefined, a press yields one key_valid pulse.
//
// Parameters
//   SCAN_DIV        clk cycles per row slot (>= 4)
//   DEBOUNCE_SCANS  consecutive identical scans to accept a press/release (>= 1)
//   REPEAT_SCANS    scans between auto-repeat events (KEYPAD_REPEAT_EN only)
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   row[3:0]   row drive, active-low, one bit low at a time
//   col[3:0]   column sense, active-low, asynchronous
//   digit_clr  synchronous clear of the digit buffer
//   key_code   code of the last accepted key = {row_idx, col_idx}
//   key_valid  one-cycle pulse per accepted key
//   key_down   high while an accepted key is held
//   digits     last four codes {d3,d2,d1,d0}, d0 newest
module keypad_scan4x4 #(
   parameter int unsigned SCAN_DIV       = 2000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned REPEAT_SCANS   = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  row,
   input  logic [3:0]  col,
   input  logic        digit_clr,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [15:0] digits
);

   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_PRESSED  = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
      $error("keypad_scan4x4: illegal parameter value");
   end

   // Column synchroniser; resets to the idle (released) level.
   logic [3:0] col_meta;
   logic [3:0] col_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta <= '1;
         col_sync <= '1;
      end else begin
         col_meta <= col;
         col_sync <= col_meta;
      end
   end

   // Row scan timing
   logic [SW-1:0] slot_cnt;
   logic [1:0]    row_idx;
   logic          tick;
   logic          scan_end;

   assign tick     = (slot_cnt == SW'(SCAN_DIV - 1));
   assign scan_end = tick && (row_idx == 2'd3);
   assign row      = ~(4'b0001 << row_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
         row_idx  <= '0;
      end else if (tick) begin
         slot_cnt <= '0;
         row_idx  <= row_idx + 2'd1;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // Rows 0..2 are stored; row 3 is taken live from col_sync on scan_end
   // so the whole scan can be classified in that same cycle.
   logic [3:0] slot_res [0:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < 3; r++) slot_res[r] <= '1;
      end else begin
         for (int unsigned r = 0; r < 3; r++) begin
            if (tick && row_idx == 2'(r)) slot_res[r] <= col_sync;
         end
      end
   end

   // Bit index r*4+c of the pressed vector equals the key code.
   logic [15:0] pressed;
   logic        any_key;
   logic        multi_key;
   logic        single_key;
   logic [3:0]  hit_code;

   assign pressed = ~{col_sync, slot_res[2], slot_res[1], slot_res[0]};

   always_comb begin
      any_key   = 1'b0;
      multi_key = 1'b0;
      hit_code  = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (pressed[i]) begin
            if (any_key) multi_key = 1'b1;
            any_key  = 1'b1;
            hit_code = 4'(i);
         end
      end
   end

   assign single_key = any_key && !multi_key;

   // Debounce FSM, advanced only on scan_end
   logic [1:0]    state;
   logic [3:0]    cand;
   logic [CW-1:0] cnt;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
   logic [RW-1:0] rep_cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cand      <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (scan_end) begin
            case (state)
               ST_IDLE: begin
                  if (single_key) begin
                     cand <= hit_code;
                     if (DEBOUNCE_SCANS <= 1) begin
                        key_code  <= hit_code;
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        state     <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= '0;
`endif
                     end else begin
                        cnt   <= CW'(1);
                        state <= ST_DEBOUNCE;
                     end
                  end
               end
               ST_DEBOUNCE: begin
                  if (single_key && hit_code == cand) begin
                     if (cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                        key_code  <= cand;
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        state     <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= '0;
`endif
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_PRESSED: begin
                  if (!any_key) begin
                     if (DEBOUNCE_SCANS <= 1) begin
                        key_down <= 1'b0;
                        state    <= ST_IDLE;
                     end else begin
                        cnt   <= CW'(1);
                        state <= ST_RELEASE;
                     end
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt <= '0;
                  end else if (single_key && hit_code == key_code) begin
                     if (rep_cnt + 1'b1 == RW'(REPEAT_SCANS)) begin
                        rep_cnt   <= '0;
                        key_valid <= 1'b1;
                     end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                     end
`endif
                  end
               end
               default: begin  // ST_RELEASE
                  if (any_key) begin
                     state <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt <= '0;
`endif
                  end else if (cnt + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
                     key_down <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // The buffer shifts in the cycle key_valid is high, so a digit_clr in
   // that same cycle overrides the shift.
   always_ff @(posedge clk) begin
      if (rst || digit_clr) begin
         digits <= '0;
      end else if (key_valid) begin
         digits <= {digits[11:0], key_code};
      end
   end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Testbench for keypad_scan4x4 (SCAN_DIV=4, DEBOUNCE_SCANS=2, scan = 16 cycles).
// A behavioural keypad drives col from row; expected key codes are queued
// before each press and popped when key_valid fires.
module tb_keypad_scan4x4;

   localparam int unsigned SCAN = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        digit_clr = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic [15:0] digits;

   logic [15:0] keys = '0;
   logic [3:0]  exp_q [$];
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned pulses = 0;
   int unsigned base;
   logic        found;

   always #5 clk = ~clk;

   keypad_scan4x4 #(
      .SCAN_DIV      (4),
      .DEBOUNCE_SCANS(2),
      .REPEAT_SCANS  (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .col      (col),
      .digit_clr(digit_clr),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_down (key_down),
      .digits   (digits)
   );

   // Key r*4+c closed shorts row r to column c.
   always_comb begin
      col = '1;
      for (int r = 0; r < 4; r++) begin
         if (row[r] == 1'b0) begin
            for (int c = 0; c < 4; c++) begin
               if (keys[r*4+c]) col[c] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && key_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check("spurious_key_valid", 32'(key_valid), 32'd0);
         end else begin
            check("key_code_pop", 32'(key_code), 32'(exp_q.pop_front()));
            check("key_down_at_valid", 32'(key_down), 32'd1);
         end
      end
   end

   task automatic scans(input int n);
      repeat (n * SCAN) @(posedge clk);
      #1;
   endtask

   // Leaves the bench #1 after the edge that starts a new scan (row 0).
   task automatic align();
      logic [3:0] prev;
      logic       ok;
      prev = row;
      ok   = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (prev == 4'b0111 && row == 4'b1110) ok = 1'b1;
         prev = row;
      end
      check("align_found", 32'(ok), 32'd1);
   endtask

   task automatic press(input logic [3:0] code, input int hold, input int rel);
      exp_q.push_back(code);
      keys = 16'h1 << code;
      scans(hold);
      keys = '0;
      scans(rel);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] er;

      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_row", 32'(row), 32'h0E);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_down", 32'(key_down), 32'd0);
      check("rst_digits", 32'(digits), 32'h0000);
      check("rst_key_code", 32'(key_code), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         er = ~(4'b0001 << (i / 4));
         check("row_sequence", 32'(row), 32'(er));
         @(posedge clk);
         #1;
      end

      // Clean press of row2/col1 held 6 scans
      base = pulses;
      exp_q.push_back(4'h9);
`ifdef KEYPAD_REPEAT_EN
      exp_q.push_back(4'h9);
`endif
      keys = 16'h1 << 9;
      scans(6);
      check("clean_key_down", 32'(key_down), 32'd1);
      check("clean_key_code", 32'(key_code), 32'h9);
`ifdef KEYPAD_REPEAT_EN
      check("clean_pulses", pulses - base, 32'd2);
      check("clean_digits", 32'(digits), 32'h0099);
`else
      check("clean_pulses", pulses - base, 32'd1);
      check("clean_digits", 32'(digits), 32'h0009);
`endif
      keys = '0;
      scans(1);
      check("release_1scan_key_down", 32'(key_down), 32'd1);
      scans(1);
      check("release_2scan_key_down", 32'(key_down), 32'd0);

      // Sequence and buffer overflow
      digit_clr = 1'b1;
      @(posedge clk);
      #1;
      digit_clr = 1'b0;
      check("clr_digits", 32'(digits), 32'h0000);
      align();
      press(4'h3, 3, 3);
      press(4'hE, 3, 3);
      check("seq_two_digits", 32'(digits), 32'h003E);
      press(4'h1, 3, 3);
      press(4'h2, 3, 3);
      check("seq_four_digits", 32'(digits), 32'h3E12);
      press(4'h7, 3, 3);
      check("seq_overflow", 32'(digits), 32'hE127);

      // Bounce: present/absent/present single scans
      base = pulses;
      keys = 16'h1 << 5; scans(1);
      keys = '0;         scans(1);
      keys = 16'h1 << 5; scans(1);
      keys = '0;         scans(3);
      check("bounce_pulses", pulses - base, 32'd0);
      check("bounce_key_down", 32'(key_down), 32'd0);
      check("bounce_key_code", 32'(key_code), 32'h7);

      // Ghost rejection from IDLE, then extra keys while PRESSED
      base = pulses;
      keys = (16'h1 << 0) | (16'h1 << 15);
      scans(4);
      keys = '0;
      scans(3);
      check("ghost_idle_pulses", pulses - base, 32'd0);
      check("ghost_idle_key_down", 32'(key_down), 32'd0);
      exp_q.push_back(4'h5);
      keys = 16'h1 << 5;
      scans(3);
      check("ghost_held_key_down", 32'(key_down), 32'd1);
      keys = (16'h1 << 5) | (16'h1 << 10);
      scans(3);
      keys = 16'h1 << 10;
      scans(2);
      keys = '0;
      scans(3);
      check("ghost_pressed_pulses", pulses - base, 32'd1);
      check("ghost_key_code", 32'(key_code), 32'h5);
      check("ghost_digits", 32'(digits), 32'h1275);

      // digit_clr in the key_valid cycle
      exp_q.push_back(4'hA);
      keys = 16'h1 << 10;
      found = 1'b0;
      for (int i = 0; i < 4 * SCAN && !found; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) found = 1'b1;
      end
      check("clr_wait_valid", 32'(found), 32'd1);
      digit_clr = 1'b1;
      @(negedge clk);
      digit_clr = 1'b0;
      check("clr_coincident_digits", 32'(digits), 32'h0000);
      check("clr_coincident_key_code", 32'(key_code), 32'hA);
      keys = '0;
      scans(3);
      check("clr_digits_stay", 32'(digits), 32'h0000);
      align();

      // Reset in DEBOUNCE with the key still held
      keys = 16'h1 << 12;
      scans(1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_row", 32'(row), 32'h0E);
      check("midrst_key_valid", 32'(key_valid), 32'd0);
      check("midrst_key_down", 32'(key_down), 32'd0);
      check("midrst_key_code", 32'(key_code), 32'h0);
      rst = 1'b0;
      exp_q.push_back(4'hC);
      repeat (31) @(posedge clk);
      #1;
      check("midrst_not_early", 32'(key_valid), 32'd0);
      @(posedge clk);
      #1;
      check("midrst_accept_2scans", 32'(key_valid), 32'd1);
      @(posedge clk);
      #1;
      check("midrst_pulse_width", 32'(key_valid), 32'd0);
      keys = '0;
      scans(3);
      check("midrst_digits", 32'(digits), 32'h000C);

      // Long hold: auto-repeat when enabled, single pulse otherwise
      digit_clr = 1'b1;
      @(posedge clk);
      #1;
      digit_clr = 1'b0;
      align();
      base = pulses;
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(4'h5);
`else
      exp_q.push_back(4'h5);
`endif
      keys = 16'h1 << 5;
      scans(12);
      keys = '0;
      scans(3);
`ifdef KEYPAD_REPEAT_EN
      check("hold_pulses", pulses - base, 32'd4);
      check("hold_digits", 32'(digits), 32'h5555);
`else
      check("hold_pulses", pulses - base, 32'd1);
      check("hold_digits", 32'(digits), 32'h0005);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
